// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, imem fetch, IF/ID register with one-entry skid
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  fetch_unit_if.master       imem,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic [5:0]         opcode
);

  typedef enum logic [1:0] {BOOT, FETCH, STALLED} stateType;

  stateType    state, stateNext;
  logic [31:0] pc, pcNext, pcPlus4;
  logic [31:0] skidInstr, skidInstrNext, skidPc4, skidPc4Next;
  logic        validNext;
  logic [31:0] instrNext, pc4Next;
  logic        redirect;

  assign pcPlus4        = pc + 32'd4;
  assign redirect       = (state != BOOT) && (branch_taken || jump);
  assign imem.imem_req  = rst_n && (state == FETCH);
  assign imem.imem_addr = rst_n ? pc : RESET_PC;
  assign opcode         = if_id_instr[31:26];

  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    validNext     = if_id_valid;
    instrNext     = if_id_instr;
    pc4Next       = if_id_pc4;
    skidInstrNext = skidInstr;
    skidPc4Next   = skidPc4;
    case (state)
      BOOT: stateNext = FETCH;
      FETCH: begin
        if (imem.imem_ready) begin
          pcNext = pcPlus4;
          // ID is busy: park the returned word instead of losing it
          if (stall) begin
            skidInstrNext = imem.imem_rdata;
            skidPc4Next   = pcPlus4;
            stateNext     = STALLED;
          end else begin
            validNext = 1'b1;
            instrNext = imem.imem_rdata;
            pc4Next   = pcPlus4;
          end
        end else if (!stall) begin
          validNext = 1'b0;
          instrNext = 32'h0000_0000;
        end
      end
      STALLED: begin
        if (!stall) begin
          validNext = 1'b1;
          instrNext = skidInstr;
          pc4Next   = skidPc4;
          stateNext = FETCH;
        end
      end
      default: stateNext = BOOT;
    endcase
    // Redirect wins over everything above, including stall and a same-cycle response
    if (redirect) begin
      if (branch_taken) pcNext = branch_target & 32'hFFFF_FFFC;
      else              pcNext = {if_id_pc4[31:28], jump_index, 2'b00};
      validNext     = 1'b0;
      instrNext     = 32'h0000_0000;
      skidInstrNext = 32'h0000_0000;
      skidPc4Next   = 32'h0000_0000;
      stateNext     = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_instr <= 32'h0000_0000;
      if_id_pc4   <= 32'h0000_0000;
      skidInstr   <= 32'h0000_0000;
      skidPc4     <= 32'h0000_0000;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      if_id_valid <= validNext;
      if_id_instr <= instrNext;
      if_id_pc4   <= pc4Next;
      skidInstr   <= skidInstrNext;
      skidPc4     <= skidPc4Next;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 stall  input  1  ID stage cannot accept a new instruction; IF/ID register holds.
REQ-005 branch_taken  input  1  taken BEQ resolved downstream; redirect to branch_target.
REQ-006 branch_target  input  32  branch destination byte address.
REQ-007 jump  input  1  J decoded in ID; redirect to jump target.
REQ-008 jump_index  input  26  instr_index field of the J instruction.
REQ-009 imem_req  output  1  instruction memory read request.
REQ-010 imem_addr  output  32  word-aligned fetch address, equal to current PC.
REQ-011 imem_ready  input  1  imem_rdata valid this cycle for the request at imem_addr.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-014 if_id_instr  output  32  IF/ID instruction word.
REQ-015 if_id_pc4  output  32  address of the IF/ID instruction plus 4.
REQ-016 opcode  output  6  combinational if_id_instr[31:26], fed to the main control decoder.

Function
REQ-017 Three states: BOOT, FETCH, STALLED.
REQ-018 BOOT: imem_req=0; unconditional transition to FETCH next cycle.
REQ-019 FETCH: imem_req=1, imem_addr=pc; requests may be held over any number of cycles until imem_ready.
REQ-020 FETCH, imem_ready=1, stall=0: IF/ID <= {valid=1, imem_rdata, pc+4}; pc <= pc+4; remain FETCH.
REQ-021 FETCH, imem_ready=1, stall=1: IF/ID holds; imem_rdata and pc+4 captured in a one-entry skid buffer; pc <= pc+4; go STALLED.
REQ-022 FETCH, imem_ready=0, stall=0: IF/ID loads bubble (valid=0, instr=32'h0, pc4 unchanged).
REQ-023 FETCH, imem_ready=0, stall=1: IF/ID holds.
REQ-024 STALLED: imem_req=0; while stall=1, IF/ID and skid hold; when stall=0, skid contents move to IF/ID with valid=1 and state returns to FETCH.
REQ-025 A bubble is always instr=32'h0000_0000 (NOP), so opcode=6'b000000 with valid=0.
REQ-026 Redirect when branch_taken or jump is 1, in any state except BOOT: pc <= target; IF/ID loads bubble; skid discarded; any imem_rdata accepted that cycle discarded; next state FETCH.
REQ-027 Redirect overrides stall.
REQ-028 branch_taken has priority over jump when both are 1.
REQ-029 Jump target = {if_id_pc4[31:28], jump_index, 2'b00}.
REQ-030 Branch target bits [1:0] are forced to 2'b00.
REQ-031 PC increment is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.
REQ-032 Fetch latency: an instruction returned with imem_ready in cycle N appears on if_id_* in cycle N+1 when stall=0.
REQ-033 Instructions are never duplicated or dropped except by redirect.

Reset
REQ-034 rst_n=0 at a clock edge sets: pc=RESET_PC, state=BOOT, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc4=0, skid empty.
REQ-035 Reset overrides all other inputs, including mid-request and in STALLED; a pending imem response is ignored.
REQ-036 imem_addr=RESET_PC during reset and in BOOT.

Verification
REQ-037 Reset release, imem always ready, words 0x20080005, 0x20090003 -> imem_req=0 for one cycle (BOOT), then if_id_instr=0x20080005/pc4=0x4, then 0x20090003/pc4=0x8, opcode=6'b001000.
REQ-038 stall=1 for 3 cycles while a word returns at pc=0x8 -> IF/ID holds the prior instruction, imem_req=0 in STALLED, and the word appears with pc4=0xC one cycle after stall falls; no duplicate and no loss.
REQ-039 branch_taken=1 with branch_target=0x40 and stall=1 asserted in the same cycle -> next cycle if_id_valid=0, instr=0; imem_addr=0x40; the stalled skid word is never issued.
REQ-040 jump=1, jump_index=0x0000010, if_id_pc4=0x1000_0004 -> imem_addr=0x1000_0040; branch_taken and jump both 1 -> branch_target wins.
REQ-041 RESET_PC=0xFFFF_FFFC, imem ready -> first if_id_pc4=0x0000_0000; next imem_addr=0x0.
REQ-042 rst_n=0 asserted while in STALLED with imem_ready=1 -> all REQ-034 values the next cycle; a fresh fetch from RESET_PC follows BOOT.
